// File: rtl/sample_merge_pkg.sv
// Shared types and output word layout for sample_merge.
// Word: {ch[1:0], drop, seq[4:0], I[11:0], Q[11:0]}.
package sample_merge_pkg;

  localparam int NUM_CH       = 4;
  localparam int CH_WIDTH     = 2;
  localparam int SEQ_WIDTH    = 5;
  localparam int SAMPLE_WIDTH = 12;
  localparam int ENTRY_WIDTH  = 1 + SEQ_WIDTH + 2 * SAMPLE_WIDTH;

  localparam int CH_MSB   = 31;
  localparam int DROP_BIT = 29;
  localparam int SEQ_MSB  = 28;
  localparam int SEQ_LSB  = 24;
  localparam int I_MSB    = 23;
  localparam int Q_MSB    = 11;

  typedef logic [CH_WIDTH-1:0] ch_t;

  typedef struct packed {
    logic                    drop;
    logic [SEQ_WIDTH-1:0]    seq;
    logic [SAMPLE_WIDTH-1:0] i;
    logic [SAMPLE_WIDTH-1:0] q;
  } entry_t;

  function automatic logic [31:0] pack_word(input ch_t ch, input entry_t e);
    logic [31:0] w;
    w                          = '0;
    w[CH_MSB -: CH_WIDTH]      = ch;
    w[DROP_BIT]                = e.drop;
    w[SEQ_MSB:SEQ_LSB]         = e.seq;
    w[I_MSB -: SAMPLE_WIDTH]   = e.i;
    w[Q_MSB -: SAMPLE_WIDTH]   = e.q;
    return w;
  endfunction

endpackage

// File: rtl/sample_merge_if.sv
// Channel inputs and merged ready/valid output of sample_merge.
// master = sample source / uplink side, slave = the merger.
interface sample_merge_if;

  logic        din_valid_0, din_valid_1, din_valid_2, din_valid_3;
  logic [11:0] data_i0_in, data_i1_in, data_i2_in, data_i3_in;
  logic [11:0] data_q0_in, data_q1_in, data_q2_in, data_q3_in;

  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_last;

  modport master (
    output din_valid_0, din_valid_1, din_valid_2, din_valid_3,
    output data_i0_in, data_i1_in, data_i2_in, data_i3_in,
    output data_q0_in, data_q1_in, data_q2_in, data_q3_in,
    output dout_ready,
    input  dout_valid, dout_data, dout_last
  );

  modport slave (
    input  din_valid_0, din_valid_1, din_valid_2, din_valid_3,
    input  data_i0_in, data_i1_in, data_i2_in, data_i3_in,
    input  data_q0_in, data_q1_in, data_q2_in, data_q3_in,
    input  dout_ready,
    output dout_valid, dout_data, dout_last
  );

endinterface

// File: rtl/sample_merge_fifo.sv
// Single-clock count-based FIFO with first-word-fall-through output.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sample_merge_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
) (
  input  logic             data_clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; occupancy is tracked by count, so stale
  // contents are never observable and the array can map onto plain RAM/flops.
  always_ff @(posedge data_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge data_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/sample_merge.sv
// Buffers four filtered I/Q channels and merges them round-robin into one tagged stream.
// Optional frame marker on dout_last when SAMPLE_MERGE_TLAST_EN is defined.
module sample_merge
  import sample_merge_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 64
) (
  input  logic              data_clk,
  input  logic              rst,
  sample_merge_if.slave     bus,
  output logic [NUM_CH-1:0] drop_sticky
);

  logic [NUM_CH-1:0]       in_valid, full, empty, push, pop;
  logic [SAMPLE_WIDTH-1:0] in_i [NUM_CH];
  logic [SAMPLE_WIDTH-1:0] in_q [NUM_CH];
  logic [SEQ_WIDTH-1:0]    seq  [NUM_CH];
  logic [NUM_CH-1:0]       drop_pending;
  entry_t                  fifo_din  [NUM_CH];
  entry_t                  fifo_dout [NUM_CH];

  assign in_valid = {bus.din_valid_3, bus.din_valid_2, bus.din_valid_1, bus.din_valid_0};
  assign in_i[0] = bus.data_i0_in;
  assign in_i[1] = bus.data_i1_in;
  assign in_i[2] = bus.data_i2_in;
  assign in_i[3] = bus.data_i3_in;
  assign in_q[0] = bus.data_q0_in;
  assign in_q[1] = bus.data_q1_in;
  assign in_q[2] = bus.data_q2_in;
  assign in_q[3] = bus.data_q3_in;

  // full is the registered occupancy, so a same-cycle pop never rescues a push
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]     = in_valid[c] && !full[c];
      fifo_din[c] = '{drop: drop_pending[c], seq: seq[c], i: in_i[c], q: in_q[c]};
    end
  end

  always_ff @(posedge data_clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) seq[c] <= '0;
      drop_pending <= '0;
      drop_sticky  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[c]) begin
          seq[c] <= seq[c] + 1'b1;
          if (full[c]) begin
            drop_pending[c] <= 1'b1;
            drop_sticky[c]  <= 1'b1;
          end else begin
            drop_pending[c] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    sample_merge_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
      .data_clk (data_clk),
      .rst      (rst),
      .push     (push[g]),
      .pop      (pop[g]),
      .din      (fifo_din[g]),
      .dout     (fifo_dout[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  ch_t         rr_ptr, sel, idx;
  logic        any, load, out_valid;
  logic [31:0] out_data;

  // NOTE: every combinational output gets a default before the loop; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    sel = rr_ptr;
    idx = rr_ptr;
    any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_ptr + ch_t'(k);
      if (!any && !empty[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  assign load = !out_valid || bus.dout_ready;
  assign pop  = (load && any) ? (NUM_CH'(1) << sel) : '0;

  always_ff @(posedge data_clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= pack_word(sel, fifo_dout[sel]);
        rr_ptr   <= sel + 1'b1;
      end
    end
  end

  assign bus.dout_valid = out_valid;
  assign bus.dout_data  = out_data;

`ifdef SAMPLE_MERGE_TLAST_EN
  localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  logic [WC_W-1:0] word_cnt;

  always_ff @(posedge data_clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_valid && bus.dout_ready) begin
      word_cnt <= (word_cnt == WC_W'(FRAME_LEN - 1)) ? '0 : word_cnt + 1'b1;
    end
  end

  // word_cnt only advances on acceptance, so the marker holds through a stall
  assign bus.dout_last = out_valid && (word_cnt == WC_W'(FRAME_LEN - 1));
`else
  // FRAME_LEN only matters with framing enabled; this is a constant 0
  assign bus.dout_last = (FRAME_LEN < 0);
`endif

endmodule

// File: tb/tb_sample_merge.sv
// Scoreboard bench for sample_merge: per-channel expected words, optional order check,
// stall-hold monitor and frame-marker check (SAMPLE_MERGE_TLAST_EN aware).
module tb_sample_merge;

  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LEN  = 4;

  logic        data_clk = 1'b0;
  logic        rst      = 1'b1;
  logic        ready    = 1'b0;
  logic [3:0]  drop_sticky;
  logic        vin [4];
  logic [11:0] iin [4];
  logic [11:0] qin [4];

  sample_merge_if bus ();

  assign bus.din_valid_0 = vin[0];
  assign bus.din_valid_1 = vin[1];
  assign bus.din_valid_2 = vin[2];
  assign bus.din_valid_3 = vin[3];
  assign bus.data_i0_in  = iin[0];
  assign bus.data_i1_in  = iin[1];
  assign bus.data_i2_in  = iin[2];
  assign bus.data_i3_in  = iin[3];
  assign bus.data_q0_in  = qin[0];
  assign bus.data_q1_in  = qin[1];
  assign bus.data_q2_in  = qin[2];
  assign bus.data_q3_in  = qin[3];
  assign bus.dout_ready  = ready;

  sample_merge #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_LEN  (FRAME_LEN)
  ) dut (
    .data_clk    (data_clk),
    .rst         (rst),
    .bus         (bus.slave),
    .drop_sticky (drop_sticky)
  );

  always #5 data_clk = ~data_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [4:0]  m_seq  [4];
  bit          m_pend [4];
  logic [31:0] exp_q  [4][$];
  int          ord_q  [$];
  bit          check_order = 1'b0;
  int          acc_cnt     = 0;

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic clear_in();
    for (int c = 0; c < 4; c++) begin
      vin[c] = 1'b0;
      iin[c] = '0;
      qin[c] = '0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_seq[c]  = '0;
      m_pend[c] = 1'b0;
      exp_q[c].delete();
    end
    ord_q.delete();
    acc_cnt = 0;
  endtask

  // drive one sample on channel c; dropped says whether the scenario overflows it
  task automatic stim(input int c, input logic [11:0] i, input logic [11:0] q, input bit dropped);
    vin[c] = 1'b1;
    iin[c] = i;
    qin[c] = q;
    if (dropped) begin
      m_pend[c] = 1'b1;
    end else begin
      exp_q[c].push_back({2'(c), m_pend[c], m_seq[c], i, q});
      if (check_order) ord_q.push_back(c);
      m_pend[c] = 1'b0;
    end
    m_seq[c] = m_seq[c] + 5'd1;
  endtask

  task automatic step(input logic [3:0] vmask, input logic [3:0] dmask);
    @(posedge data_clk); #1;
    clear_in();
    for (int c = 0; c < 4; c++)
      if (vmask[c]) stim(c, 12'($urandom), 12'($urandom), dmask[c]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge data_clk); #1;
      clear_in();
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((pending() > 0 || bus.dout_valid) && n < max_cycles) begin
      @(posedge data_clk); #1;
      clear_in();
      n++;
    end
    @(negedge data_clk);
    check("drain_left", 32'(pending()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge data_clk); #1;
    ready = 1'b0;
    clear_in();
    rst = 1'b1;
    @(posedge data_clk);
    @(negedge data_clk);
    check("rst_valid",  32'(bus.dout_valid), 32'd0);
    check("rst_data",   bus.dout_data,       32'd0);
    check("rst_last",   32'(bus.dout_last),  32'd0);
    check("rst_sticky", 32'(drop_sticky),    32'd0);
    model_reset();
    @(posedge data_clk); #1;
    rst = 1'b0;
  endtask

  // output monitor: scoreboard, order, stall-hold and frame-marker checks
  bit          stall_prev = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  always @(negedge data_clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus.dout_valid), 32'd1);
        check("hold_data",  bus.dout_data,       held_data);
        check("hold_last",  32'(bus.dout_last),  32'(held_last));
      end
      stall_prev = bus.dout_valid && !ready;
      held_data  = bus.dout_data;
      held_last  = bus.dout_last;
      if (bus.dout_valid && ready) begin
        automatic int  ch = int'(bus.dout_data[31:30]);
        automatic logic exp_last;
`ifdef SAMPLE_MERGE_TLAST_EN
        exp_last = ((acc_cnt % FRAME_LEN) == FRAME_LEN - 1);
`else
        exp_last = 1'b0;
`endif
        if (exp_q[ch].size() == 0) check("extra_word", 32'(exp_q[ch].size()), 32'd1);
        else                       check("word", bus.dout_data, exp_q[ch].pop_front());
        if (check_order) begin
          if (ord_q.size() == 0) check("order_extra", 32'(ord_q.size()), 32'd1);
          else                   check("order", 32'(ch), 32'(ord_q.pop_front()));
        end
        check("last", 32'(bus.dout_last), 32'(exp_last));
        acc_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    model_reset();
    do_reset();

    // single sample on ch2 with exact latency and one-cycle valid
    @(posedge data_clk); #1;
    ready = 1'b1;
    idle(1);
    @(posedge data_clk); #1;
    clear_in();
    stim(2, 12'h123, 12'hABC, 1'b0);
    @(negedge data_clk);
    check("lat_c0_valid", 32'(bus.dout_valid), 32'd0);
    @(posedge data_clk); #1;
    clear_in();
    @(negedge data_clk);
    check("lat_c1_valid", 32'(bus.dout_valid), 32'd0);
    @(negedge data_clk);
    check("lat_c2_valid", 32'(bus.dout_valid), 32'd1);
    check("lat_c2_data",  bus.dout_data,       32'h80123ABC);
    @(negedge data_clk);
    check("lat_c3_valid", 32'(bus.dout_valid), 32'd0);
    drain(20);

    // all channels, four cycles: strict 0,1,2,3 order
    do_reset();
    ready       = 1'b1;
    check_order = 1'b1;
    for (int k = 0; k < 4; k++) step(4'b1111, 4'b0000);
    drain(60);
    check_order = 1'b0;
    check("order_left",    32'(ord_q.size()), 32'd0);
    check("nodrop_sticky", 32'(drop_sticky),  32'd0);

    // backpressure overflow on ch0
    do_reset();
    for (int k = 0; k < 10; k++) step(4'b0001, (k == 9) ? 4'b0001 : 4'b0000);
    idle(2);
    @(negedge data_clk);
    check("bp_sticky",   32'(drop_sticky),           32'b0001);
    check("bp_valid",    32'(bus.dout_valid),        32'd1);
    check("bp_slot_seq", 32'(bus.dout_data[28:24]),  32'd0);
    @(posedge data_clk); #1;
    ready = 1'b1;
    drain(40);
    step(4'b0001, 4'b0000);
    drain(20);
    check("bp_sticky_kept", 32'(drop_sticky), 32'b0001);

    // toggling ready while three channels stream
    do_reset();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge data_clk); #1;
          ready = k[0];
        end
      end
      begin
        for (int k = 0; k < 6; k++) step(4'b1011, 4'b0000);
        idle(1);
      end
    join
    @(posedge data_clk); #1;
    ready = 1'b1;
    drain(60);
    check("stall_sticky", 32'(drop_sticky), 32'd0);

    // reset with buffered data: nothing stale must emerge
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b1111, 4'b0000);
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge data_clk);
      check("post_rst_idle", 32'(bus.dout_valid), 32'd0);
    end

    // seq wrap on ch1 (first word after reset carries seq 0)
    for (int k = 0; k < 33; k++) step(4'b0010, 4'b0000);
    drain(60);

    // frame marker across a mid-frame reset
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 6; k++) step(4'b0001, 4'b0000);
    drain(30);
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) step(4'b0100, 4'b0000);
    drain(30);
    check("frame_words", 32'(acc_cnt), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
